// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the pipeline-stage buffer and the RV32I field decoder.
// The opcode enum and XLEN default are used by every stage that carries instructions.
package pipe_stage_buf_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN         = 32;

  typedef enum logic [6:0] {
    OPC_NONE     = 7'h00,
    OPC_LOAD     = 7'h03,
    OPC_MISC_MEM = 7'h0F,
    OPC_OP_IMM   = 7'h13,
    OPC_AUIPC    = 7'h17,
    OPC_STORE    = 7'h23,
    OPC_OP       = 7'h33,
    OPC_LUI      = 7'h37,
    OPC_BRANCH   = 7'h63,
    OPC_JALR     = 7'h67,
    OPC_JAL      = 7'h6F,
    OPC_SYSTEM   = 7'h73
  } rv32i_opcode;

  // A single-entry buffer still needs a one-bit pointer so the storage index is never zero-width.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_instr_decode.sv
// Purely combinational RV32I field and immediate decoder.
// Shared by any stage that needs register indices or sign-extended immediates.
module instr_decode
  import pipe_stage_buf_pkg::*;
(
  input  logic [ILEN-1:0] instr_i,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output rv32i_opcode     opcode_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [31:0]     iImm_o,
  output logic [31:0]     sImm_o,
  output logic [31:0]     bImm_o,
  output logic [31:0]     uImm_o,
  output logic [31:0]     jImm_o
);

  assign funct3_o = instr_i[14:12];
  assign funct7_o = instr_i[31:25];
  assign opcode_o = rv32i_opcode'(instr_i[6:0]);
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign rd_o     = instr_i[11:7];

  // Immediate bit positions are scrambled in B/J formats so the sign bit is always instr[31].
  assign iImm_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign sImm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign bImm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
  assign uImm_o = {instr_i[31:12], 12'h000};
  assign jImm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline-stage register with flush, stall counter and head decode.
// DEPTH=2 forms a skid buffer so in_ready depends only on registered occupancy.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEFAULT,
  parameter  int NLANES = 4,
  parameter  int DEPTH  = 2,
  localparam int OW     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ILEN-1:0]        in_instr,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [NLANES*XLEN-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ILEN-1:0]        out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [NLANES*XLEN-1:0] out_data,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7,
  output rv32i_opcode            opcode,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [4:0]             rd,
  output logic [31:0]            i_imm,
  output logic [31:0]            s_imm,
  output logic [31:0]            b_imm,
  output logic [31:0]            u_imm,
  output logic [31:0]            j_imm,
  output logic [OW-1:0]          occupancy,
  output logic [31:0]            stall_cycles
);

  localparam int PW = ptrWidth(DEPTH);

  logic [ILEN-1:0]        instrMem_q [DEPTH];
  logic [XLEN-1:0]        pcMem_q    [DEPTH];
  logic [NLANES*XLEN-1:0] dataMem_q  [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [31:0]   stallCnt_q, stallCnt_d;

  logic doPush;
  logic doPop;

  function automatic logic [PW-1:0] bumpPtr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign in_ready  = (occ_q < OW'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign occupancy = occ_q;
  assign stall_cycles = stallCnt_q;

  assign doPush = in_valid && in_ready;
  assign doPop  = out_valid && out_ready;

  // Flush overrides both handshakes; the stall counter keeps running regardless.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    stallCnt_d = stallCnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (doPush) begin
        tail_d = bumpPtr(tail_q);
      end
      if (doPop) begin
        head_d = bumpPtr(head_q);
      end
      case ({doPush, doPop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
    if (out_valid && !out_ready && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      stallCnt_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        instrMem_q[e] <= '0;
        pcMem_q[e]    <= '0;
        dataMem_q[e]  <= '0;
      end
    end else if (doPush && !flush) begin
      instrMem_q[tail_q] <= in_instr;
      pcMem_q[tail_q]    <= in_pc;
      dataMem_q[tail_q]  <= in_data;
    end
  end

  // Stale storage behind a flushed or popped head must never leak downstream.
  assign out_instr = out_valid ? instrMem_q[head_q] : '0;
  assign out_pc    = out_valid ? pcMem_q[head_q]    : '0;
  assign out_data  = out_valid ? dataMem_q[head_q]  : '0;

  instr_decode u_decode (
    .instr_i  (out_instr),
    .funct3_o (funct3),
    .funct7_o (funct7),
    .opcode_o (opcode),
    .rs1_o    (rs1),
    .rs2_o    (rs2),
    .rd_o     (rd),
    .iImm_o   (i_imm),
    .sImm_o   (s_imm),
    .bImm_o   (b_imm),
    .uImm_o   (u_imm),
    .jImm_o   (j_imm)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: decode vector table plus skid, stream, flush and stall sequences.
module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;

  localparam int XLEN   = 32;
  localparam int NLANES = 4;
  localparam int DEPTH  = 2;
  localparam int OW     = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [XLEN-1:0]        in_pc;
  logic [NLANES*XLEN-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_instr;
  logic [XLEN-1:0]        out_pc;
  logic [NLANES*XLEN-1:0] out_data;
  logic [2:0]             funct3;
  logic [6:0]             funct7;
  logic [6:0]             opcode;
  logic [4:0]             rs1, rs2, rd;
  logic [31:0]            i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [OW-1:0]          occupancy;
  logic [31:0]            stall_cycles;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] iImm, sImm, bImm, uImm, jImm;
  } decodeVec_t;

  decodeVec_t vecs [6];

  pipe_stage_buf #(.XLEN(XLEN), .NLANES(NLANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_data(out_data),
    .funct3(funct3), .funct7(funct7), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
    .i_imm(i_imm), .s_imm(s_imm), .b_imm(b_imm), .u_imm(u_imm), .j_imm(j_imm),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NLANES*XLEN-1:0] lanesFor(input logic [31:0] pc);
    logic [NLANES*XLEN-1:0] d;
    for (int i = 0; i < NLANES; i++) begin
      d[i*XLEN +: XLEN] = pc + 32'(i) * 32'h0100_0000;
    end
    return d;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    in_data   = lanesFor(pc);
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0050_0093, 7'h13, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00,
                32'h0000_0005, 32'h0000_0001, 32'h0000_0800, 32'h0050_0000, 32'h0000_0804};
    vecs[1] = '{32'hFFF0_0113, 7'h13, 5'd2,  5'd0,  5'd31, 3'd0, 7'h7F,
                32'hFFFF_FFFF, 32'hFFFF_FFE2, 32'hFFFF_F7E2, 32'hFFF0_0000, 32'hFFF0_0FFE};
    vecs[2] = '{32'h0051_2423, 7'h23, 5'd8,  5'd2,  5'd5,  3'd2, 7'h00,
                32'h0000_0005, 32'h0000_0008, 32'h0000_0008, 32'h0051_2000, 32'h0001_2804};
    vecs[3] = '{32'hFE20_8EE3, 7'h63, 5'd29, 5'd1,  5'd2,  3'd0, 7'h7F,
                32'hFFFF_FFE2, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'hFE20_8000, 32'hFFF0_87E2};
    vecs[4] = '{32'hABCD_E537, 7'h37, 5'd10, 5'd27, 5'd28, 3'd6, 7'h55,
                32'hFFFF_FABC, 32'hFFFF_FAAA, 32'hFFFF_F2AA, 32'hABCD_E000, 32'hFFFD_E2BC};
    vecs[5] = '{32'hFF9F_F0EF, 7'h6F, 5'd1,  5'd31, 5'd25, 3'd7, 7'h7F,
                32'hFFFF_FFF9, 32'hFFFF_FFE1, 32'hFFFF_FFE0, 32'hFF9F_F000, 32'hFFFF_FFF8};

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_stall", stall_cycles, 32'd0);
    checkOutput("rst_opcode", 32'(opcode), 32'd0);
    checkOutput("rst_out_data", out_data[31:0], 32'd0);
    tick();
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, vecs[k].instr, 32'h60 + 32'(k * 4), 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("dec_valid", 32'(out_valid), 32'd1);
      checkOutput("dec_pc", out_pc, 32'h60 + 32'(k * 4));
      checkOutput("dec_instr", out_instr, vecs[k].instr);
      checkOutput("dec_opcode", 32'(opcode), 32'(vecs[k].opcode));
      checkOutput("dec_rd", 32'(rd), 32'(vecs[k].rd));
      checkOutput("dec_rs1", 32'(rs1), 32'(vecs[k].rs1));
      checkOutput("dec_rs2", 32'(rs2), 32'(vecs[k].rs2));
      checkOutput("dec_funct3", 32'(funct3), 32'(vecs[k].f3));
      checkOutput("dec_funct7", 32'(funct7), 32'(vecs[k].f7));
      checkOutput("dec_i_imm", i_imm, vecs[k].iImm);
      checkOutput("dec_s_imm", s_imm, vecs[k].sImm);
      checkOutput("dec_b_imm", b_imm, vecs[k].bImm);
      checkOutput("dec_u_imm", u_imm, vecs[k].uImm);
      checkOutput("dec_j_imm", j_imm, vecs[k].jImm);
      tick();
      checkOutput("dec_popped", 32'(out_valid), 32'd0);
    end

    // Skid: fill both entries with downstream stalled, then drain in order.
    applyStimulus(1'b1, 32'h0000_0A13, 32'h100, 1'b0, 1'b0);
    tick();
    checkOutput("skid_in_ready_1", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 32'h0000_0B13, 32'h104, 1'b0, 1'b0);
    tick();
    checkOutput("skid_occ_full", 32'(occupancy), 32'd2);
    checkOutput("skid_in_ready_full", 32'(in_ready), 32'd0);
    checkOutput("skid_head_pc", out_pc, 32'h100);
    applyStimulus(1'b1, 32'h0000_0C13, 32'h108, 1'b0, 1'b0);
    tick();
    checkOutput("skid_no_third", 32'(occupancy), 32'd2);
    checkOutput("skid_head_still_a", out_pc, 32'h100);
    checkOutput("skid_lane3_a", out_data[3*XLEN +: XLEN], 32'h0300_0100);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("skid_b_pc", out_pc, 32'h104);
    checkOutput("skid_b_instr", out_instr, 32'h0000_0B13);
    checkOutput("skid_occ_1", 32'(occupancy), 32'd1);
    tick();
    checkOutput("skid_drained", 32'(occupancy), 32'd0);
    checkOutput("skid_drained_pc", out_pc, 32'd0);

    // Stream: push and pop every cycle, occupancy pinned at 1.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'h0000_0013 | (32'(i) << 20), 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
      tick();
      checkOutput("stream_pc", out_pc, 32'h1000 + 32'(i * 4));
      checkOutput("stream_occ", 32'(occupancy), 32'd1);
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("stream_end_occ", 32'(occupancy), 32'd0);

    // Flush while full with a competing input.
    applyStimulus(1'b1, 32'h0000_0113, 32'h200, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_0213, 32'h204, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_0313, 32'hDEAD, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_occ", 32'(occupancy), 32'd0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_pc", out_pc, 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("flush_stays_empty", 32'(out_valid), 32'd0);
    end

    // Flush with one entry held, so the competing input would otherwise be accepted.
    applyStimulus(1'b1, 32'h0000_0413, 32'h300, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0000_0513, 32'hBEEF, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush1_occ", 32'(occupancy), 32'd0);
    tick();
    checkOutput("flush1_no_leak", out_pc, 32'd0);

    // Stall counter: count, survive flush, clear on reset, saturate.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("stall_cleared", stall_cycles, 32'd0);
    applyStimulus(1'b1, 32'h0000_0613, 32'h400, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (10) tick();
    checkOutput("stall_10", stall_cycles, 32'd10);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("stall_after_flush", stall_cycles, 32'd10);
    applyStimulus(1'b1, 32'h0000_0713, 32'h404, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_mid_occ_pre", 32'(occupancy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_stall", stall_cycles, 32'd0);
    checkOutput("rst_mid_occ", 32'(occupancy), 32'd0);
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);

    applyStimulus(1'b1, 32'h0000_0813, 32'h500, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    force dut.stallCnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stallCnt_q;
    tick();
    checkOutput("stall_reach_max", stall_cycles, 32'hFFFF_FFFF);
    tick();
    checkOutput("stall_saturate", stall_cycles, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
